// File: rtl/simple0_pkg.sv
// Shared types, sizes and the reference behaviour of the simple0 combinational block.
package simple0_pkg;

    localparam int VEC_W   = 4;
    localparam int NUM_VEC = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        FIN
    } state_t;

    // Returns the expected {o1, o2} pair for one input combination.
    function automatic logic [1:0] golden_resp(input logic a, input logic b,
                                               input logic c, input logic d);
        logic o1;
        logic o2;
        o2 = a | b | d;
        o1 = (a | b | d) & ~((a | b) & c);
        return {o1, o2};
    endfunction

endpackage

// File: rtl/simple0_golden.sv
// Combinational reference model of simple0, used by the checker as the expected response.
module simple0_golden
    import simple0_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic o1,
    output logic o2
);

    logic [1:0] w_resp;

    // Evaluate the reference function for the current stimulus.
    always_comb begin
        w_resp = golden_resp(a, b, c, d);
    end

    assign o1 = w_resp[1];
    assign o2 = w_resp[0];

endmodule

// File: rtl/simple0_checker.sv
// Exhaustive sweep checker for simple0: walks all 16 input vectors, lets each one
// settle for SETTLE_CYCLES clocks, compares the response against the reference model
// and reports a mismatch count plus the lowest failing vector.
module simple0_checker
    import simple0_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       dut_a,
    output logic       dut_b,
    output logic       dut_c,
    output logic       dut_d,
    input  logic       dut_o1,
    input  logic       dut_o2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail_vec,
    output logic       first_fail_valid
);

    localparam logic [7:0]       CNT_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VEC - 1);
    localparam logic [4:0]       ERR_MAX  = 5'(NUM_VEC);

    state_t           r_state;
    logic [VEC_W-1:0] r_vec;
    logic [7:0]       r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [4:0]       r_errCount;
    logic [3:0]       r_firstFailVec;
    logic             r_firstFailValid;

    logic             w_goldO1;
    logic             w_goldO2;
    logic             w_mismatch;

    // The stimulus bits come straight from the vector register, MSB first.
    assign dut_a = r_vec[3];
    assign dut_b = r_vec[2];
    assign dut_c = r_vec[1];
    assign dut_d = r_vec[0];

    simple0_golden u_golden (
        .a  (r_vec[3]),
        .b  (r_vec[2]),
        .c  (r_vec[1]),
        .d  (r_vec[0]),
        .o1 (w_goldO1),
        .o2 (w_goldO2)
    );

    assign w_mismatch = ({dut_o1, dut_o2} != {w_goldO1, w_goldO2});

    // Sweep sequencer with all status outputs registered; results persist in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_vec            <= '0;
            r_cnt            <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_errCount       <= '0;
            r_firstFailVec   <= '0;
            r_firstFailValid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_vec            <= '0;
                        r_cnt            <= '0;
                        r_errCount       <= '0;
                        r_firstFailValid <= 1'b0;
                        r_busy           <= 1'b1;
                        r_state          <= SETTLE;
                    end
                end
                SETTLE: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_mismatch) begin
                        if (r_errCount != ERR_MAX) begin
                            r_errCount <= r_errCount + 5'd1;
                        end
                        if (!r_firstFailValid) begin
                            r_firstFailVec   <= r_vec;
                            r_firstFailValid <= 1'b1;
                        end
                    end
                    if (r_vec == VEC_LAST) begin
                        r_state <= FIN;
                    end else begin
                        r_vec   <= r_vec + 1'b1;
                        r_cnt   <= '0;
                        r_state <= SETTLE;
                    end
                end
                FIN: begin
                    r_done  <= 1'b1;
                    r_pass  <= (r_errCount == 5'd0);
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_errCount;
    assign first_fail_vec   = r_firstFailVec;
    assign first_fail_valid = r_firstFailValid;

endmodule

// File: tb/tb_simple0_checker.sv
// Bench for simple0_checker: two checker instances (default settle and settle=1) sweep a
// behavioural simple0 with selectable output faults; a scoreboard matches every done pulse.
module tb_simple0_checker;

    typedef struct {
        int         startCyc;
        int         latency;
        logic [4:0] err;
        logic       pass;
        logic [3:0] ffv;
        logic       ffValid;
    } exp_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    int   fault = 0;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;

    exp_t q0[$];
    exp_t q1[$];

    logic       a0, b0, c0, d0, o1_0, o2_0, busy0, done0, pass0, ffValid0;
    logic [4:0] err0;
    logic [3:0] ffv0;
    logic       a1, b1, c1, d1, o1_1, o2_1, busy1, done1, pass1, ffValid1;
    logic [4:0] err1;
    logic [3:0] ffv1;

    // Free-running clock and cycle counter used for latency measurement.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural simple0 with fault overlay: 1 = o1 stuck at 0, 2 = o2 stuck at 1.
    function automatic logic [1:0] netlist(input logic a, input logic b, input logic c,
                                           input logic d, input int f);
        logic x, y;
        x = a | b;
        y = x | d;
        netlist = {y & ~(x & c), y};
        if (f == 1) netlist[1] = 1'b0;
        if (f == 2) netlist[0] = 1'b1;
    endfunction

    assign {o1_0, o2_0} = netlist(a0, b0, c0, d0, fault);
    assign {o1_1, o2_1} = netlist(a1, b1, c1, d1, fault);

    simple0_checker u0 (
        .clk(clk), .rst(rst), .start(start),
        .dut_a(a0), .dut_b(b0), .dut_c(c0), .dut_d(d0),
        .dut_o1(o1_0), .dut_o2(o2_0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_vec(ffv0), .first_fail_valid(ffValid0)
    );

    simple0_checker #(.SETTLE_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .start(start),
        .dut_a(a1), .dut_b(b1), .dut_c(c1), .dut_d(d1),
        .dut_o1(o1_1), .dut_o2(o2_1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_vec(ffv1), .first_fail_valid(ffValid1)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkDone(input string tag, input exp_t e, input logic [4:0] err,
                             input logic ps, input logic [3:0] ffv, input logic ffValid);
        checkOutput({tag, " latency"}, cyc - e.startCyc, e.latency);
        checkOutput({tag, " err_count"}, err, e.err);
        checkOutput({tag, " pass"}, ps, e.pass);
        checkOutput({tag, " first_fail_valid"}, ffValid, e.ffValid);
        checkOutput({tag, " first_fail_vec"}, ffv, e.ffv);
    endtask

    task automatic checkReset(input string tag, input logic bsy, input logic dn, input logic ps,
                              input logic [4:0] err, input logic [3:0] ffv, input logic ffValid,
                              input logic [3:0] vec);
        checkOutput({tag, " reset busy"}, bsy, 0);
        checkOutput({tag, " reset done"}, dn, 0);
        checkOutput({tag, " reset pass"}, ps, 0);
        checkOutput({tag, " reset err_count"}, err, 0);
        checkOutput({tag, " reset first_fail_vec"}, ffv, 0);
        checkOutput({tag, " reset first_fail_valid"}, ffValid, 0);
        checkOutput({tag, " reset dut vector"}, vec, 0);
    endtask

    // Scoreboard monitor for the default-settle instance.
    initial forever begin
        @(posedge clk);
        #1;
        if (done0 === 1'b1) begin
            if (q0.size() == 0) checkOutput("u0 unexpected done", done0, 0);
            else checkDone("u0", q0.pop_front(), err0, pass0, ffv0, ffValid0);
        end
    end

    // Scoreboard monitor for the settle=1 instance.
    initial forever begin
        @(posedge clk);
        #1;
        if (done1 === 1'b1) begin
            if (q1.size() == 0) checkOutput("u1 unexpected done", done1, 0);
            else checkDone("u1", q1.pop_front(), err1, pass1, ffv1, ffValid1);
        end
    end

    task automatic waitIdle();
        for (int i = 0; i < 300 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            checkOutput("done timeout pending", q0.size() + q1.size(), 0);
            q0.delete();
            q1.delete();
        end
    endtask

    // Launch one sweep with the given fault and expected results; optionally re-pulse start mid-sweep.
    task automatic applyStimulus(input int f, input logic [4:0] expErr, input logic expPass,
                                 input logic [3:0] expFfv, input logic expFfValid, input bit rePulse);
        exp_t e;
        @(negedge clk);
        fault = f;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.startCyc = cyc;
        e.err      = expErr;
        e.pass     = expPass;
        e.ffv      = expFfv;
        e.ffValid  = expFfValid;
        e.latency  = 81;
        q0.push_back(e);
        e.latency  = 33;
        q1.push_back(e);
        checkOutput("u0 busy after start", busy0, 1);
        @(negedge clk);
        start = 1'b0;
        if (rePulse) begin
            repeat (10) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        waitIdle();
        repeat (5) @(posedge clk);
        #1;
        checkOutput("u0 held err_count", err0, expErr);
        checkOutput("u0 held pass", pass0, expPass);
        checkOutput("u0 busy idle", busy0, 0);
    endtask

    initial begin
        int sc;
        $display("[TB] simple0_checker bench start");
        repeat (3) @(posedge clk);
        #1;
        checkReset("u0", busy0, done0, pass0, err0, ffv0, ffValid0, {a0, b0, c0, d0});
        checkReset("u1", busy1, done1, pass1, err1, ffv1, ffValid1, {a1, b1, c1, d1});
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(0, 5'd0, 1'b1, 4'd0, 1'b0, 1'b0);
        applyStimulus(1, 5'd8, 1'b0, 4'd1, 1'b1, 1'b0);
        applyStimulus(2, 5'd2, 1'b0, 4'd0, 1'b1, 1'b0);
        applyStimulus(0, 5'd0, 1'b1, 4'd0, 1'b0, 1'b1);

        // Abort a faulty sweep partway through with reset; no done may follow.
        @(negedge clk);
        fault = 1;
        start = 1'b1;
        @(posedge clk);
        #1;
        sc = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < sc + 29) @(negedge clk);
        checkOutput("u0 err before abort", (err0 != 0), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkReset("u0 abort", busy0, done0, pass0, err0, ffv0, ffValid0, {a0, b0, c0, d0});
        checkReset("u1 abort", busy1, done1, pass1, err1, ffv1, ffValid1, {a1, b1, c1, d1});
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(posedge clk);

        applyStimulus(0, 5'd0, 1'b1, 4'd0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the run wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
